// File: rtl/stage_sum_fetch.sv
// stage_sum_fetch: issues cnt reads from a ROM port and returns their signed sum.
// Optional threshold compare on the result is enabled by defining STAGE_THRESH_EN.
module stage_sum_fetch #(
  parameter int W_DATA  = 13,
  parameter int W_ADDR  = 12,
  parameter int W_CNT   = 8,
  parameter int MAX_OUT = 2,
  parameter int W_ACC   = W_DATA + W_CNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [W_ADDR-1:0] req_base,
  input  logic [W_CNT-1:0]  req_cnt,
`ifdef STAGE_THRESH_EN
  input  logic [W_ACC-1:0]  req_thr,
`endif
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [W_ADDR-1:0] addr_data,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [W_DATA-1:0] data,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [W_ACC-1:0]  sum_data,
`ifdef STAGE_THRESH_EN
  output logic              sum_pass,
`endif
  output logic              busy
);

  localparam int W_O = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state, w_state;
  logic [W_ADDR-1:0] r_addr, w_addr;
  logic              r_addr_valid, w_addr_valid;
  logic [W_CNT-1:0]  r_cnt, w_cnt;
  logic [W_CNT-1:0]  r_issued, w_issued;
  logic [W_CNT-1:0]  r_received, w_received;
  logic [W_O-1:0]    r_out, w_out;
  logic [W_ACC-1:0]  r_acc, w_acc;
  logic [W_ACC-1:0]  r_sum, w_sum;
  logic              r_sum_valid, w_sum_valid;
  logic              w_req_hs, w_addr_hs;
  logic              w_data_hs, w_sum_hs;
  logic [W_ACC-1:0]  w_data_ext;
`ifdef STAGE_THRESH_EN
  logic [W_ACC-1:0]  r_thr, w_thr;
  logic              r_pass, w_pass;
`endif

  assign req_ready  = (r_state == S_IDLE);
  assign data_ready = (r_state == S_RUN);
  assign busy       = (r_state != S_IDLE);
  assign addr_valid = r_addr_valid;
  assign addr_data  = r_addr;
  assign sum_valid  = r_sum_valid;
  assign sum_data   = r_sum;
`ifdef STAGE_THRESH_EN
  assign sum_pass   = r_pass;
`endif

  assign w_req_hs  = req_valid & req_ready;
  assign w_addr_hs = r_addr_valid & addr_ready;
  assign w_data_hs = data_valid & data_ready;
  assign w_sum_hs  = r_sum_valid & sum_ready;

  assign w_data_ext = {{(W_ACC-W_DATA){data[W_DATA-1]}}, data};

  always_comb begin
    w_state      = r_state;
    w_addr       = r_addr;
    w_addr_valid = r_addr_valid;
    w_cnt        = r_cnt;
    w_issued     = r_issued;
    w_received   = r_received;
    w_out        = r_out;
    w_acc        = r_acc;
    w_sum        = r_sum;
    w_sum_valid  = r_sum_valid;
`ifdef STAGE_THRESH_EN
    w_thr        = r_thr;
    w_pass       = r_pass;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_req_hs) begin
          w_addr       = req_base;
          w_cnt        = req_cnt;
          w_issued     = '0;
          w_received   = '0;
          w_out        = '0;
          w_acc        = '0;
          w_addr_valid = (req_cnt != '0);
          w_state      = (req_cnt == '0) ? S_DONE : S_RUN;
`ifdef STAGE_THRESH_EN
          w_thr        = req_thr;
`endif
        end
      end
      S_RUN: begin
        if (w_addr_hs) begin
          w_addr   = r_addr + W_ADDR'(1);
          w_issued = r_issued + W_CNT'(1);
        end
        if (w_addr_hs && !w_data_hs) begin
          w_out = r_out + W_O'(1);
        end else if (!w_addr_hs && w_data_hs) begin
          w_out = r_out - W_O'(1);
        end
        if (w_data_hs) begin
          w_acc      = r_acc + w_data_ext;
          w_received = r_received + W_CNT'(1);
        end
        // same-cycle returns free a slot, so the next address goes out unbroken
        w_addr_valid = (w_issued < r_cnt) &&
                       (w_out < W_O'(MAX_OUT));
        if (w_data_hs && (w_received == r_cnt)) begin
          w_addr_valid = 1'b0;
          w_state      = S_DONE;
        end
      end
      S_DONE: begin
        if (!r_sum_valid) begin
          w_sum_valid = 1'b1;
          w_sum       = r_acc;
`ifdef STAGE_THRESH_EN
          w_pass      = ($signed(r_acc) >= $signed(r_thr));
`endif
        end else if (w_sum_hs) begin
          w_sum_valid = 1'b0;
          w_state     = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_addr_valid <= 1'b0;
      r_cnt        <= '0;
      r_issued     <= '0;
      r_received   <= '0;
      r_out        <= '0;
      r_acc        <= '0;
      r_sum        <= '0;
      r_sum_valid  <= 1'b0;
`ifdef STAGE_THRESH_EN
      r_thr        <= '0;
      r_pass       <= 1'b0;
`endif
    end else begin
      r_state      <= w_state;
      r_addr       <= w_addr;
      r_addr_valid <= w_addr_valid;
      r_cnt        <= w_cnt;
      r_issued     <= w_issued;
      r_received   <= w_received;
      r_out        <= w_out;
      r_acc        <= w_acc;
      r_sum        <= w_sum;
      r_sum_valid  <= w_sum_valid;
`ifdef STAGE_THRESH_EN
      r_thr        <= w_thr;
      r_pass       <= w_pass;
`endif
    end
  end

endmodule

// File: tb/tb_stage_sum_fetch.sv
// Scoreboard bench for stage_sum_fetch with a latency-configurable ROM read-port model.
// Directed vectors with hand-computed addresses and sums.
module tb_stage_sum_fetch;

  localparam int W_DATA  = 13;
  localparam int W_ADDR  = 12;
  localparam int W_CNT   = 8;
  localparam int MAX_OUT = 2;
  localparam int W_ACC   = W_DATA + W_CNT;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [W_ADDR-1:0] req_base;
  logic [W_CNT-1:0]  req_cnt;
  logic              addr_valid;
  logic              addr_ready;
  logic [W_ADDR-1:0] addr_data;
  logic              data_valid;
  logic              data_ready;
  logic [W_DATA-1:0] data;
  logic              sum_valid;
  logic              sum_ready;
  logic [W_ACC-1:0]  sum_data;
  logic              busy;
`ifdef STAGE_THRESH_EN
  logic [W_ACC-1:0]  req_thr;
  logic              sum_pass;
`endif

  stage_sum_fetch #(
    .W_DATA (W_DATA),
    .W_ADDR (W_ADDR),
    .W_CNT  (W_CNT),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_base  (req_base),
    .req_cnt   (req_cnt),
`ifdef STAGE_THRESH_EN
    .req_thr   (req_thr),
`endif
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .addr_data (addr_data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data      (data),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data),
`ifdef STAGE_THRESH_EN
    .sum_pass  (sum_pass),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W_ADDR-1:0] a;
    int                due;
  } rd_t;

  logic [W_DATA-1:0] rom [4096];
  rd_t               pend[$];
  rd_t               rr;
  logic [W_ADDR-1:0] addrq[$];
  longint            sumq[$];
  bit                passq[$];
  int                hs_cyc[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  bit toggle = 0;
  int max_pend = 0;
  int n_av = 0;
  int n_ahs = 0;

  logic              s_addr_hs = 0;
  logic              s_data_hs = 0;
  logic [W_ADDR-1:0] s_addr = '0;
  logic [W_ADDR-1:0] exp_a;
  longint            exp_s;
  bit                exp_p;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: sample away from the active edge, score handshakes
  always @(negedge clk) begin
    s_addr_hs = addr_valid && addr_ready;
    s_data_hs = data_valid && data_ready;
    s_addr    = addr_data;
    if (rst && addr_valid) n_av++;
    if (rst && s_addr_hs) begin
      n_ahs++;
      hs_cyc.push_back(cyc);
      if (addrq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL addr_extra: got %h expected none", addr_data);
      end else begin
        exp_a = addrq.pop_front();
        chk("addr", longint'(addr_data), longint'(exp_a));
      end
    end
    if (rst && sum_valid && sum_ready) begin
      if (sumq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sum_extra: got %0d expected none",
                 $signed(sum_data));
      end else begin
        exp_s = sumq.pop_front();
        chk("sum_data", longint'($signed(sum_data)), exp_s);
`ifdef STAGE_THRESH_EN
        exp_p = passq.pop_front();
        chk("sum_pass", longint'(sum_pass), longint'(exp_p));
`endif
      end
    end
  end

  // ROM read-port model with configurable latency
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      if (s_data_hs && pend.size() > 0) pend.delete(0);
      if (s_addr_hs) begin
        rr.a   = s_addr;
        rr.due = cyc + lat - 1;
        pend.push_back(rr);
      end
      if (pend.size() > max_pend) max_pend = pend.size();
      addr_ready = toggle ? !addr_ready : 1'b1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        data_valid = 1'b1;
        data       = rom[pend[0].a];
      end else begin
        data_valid = 1'b0;
      end
    end
  end

  task automatic set_rom(input logic [W_ADDR-1:0] a, input int v);
    rom[a] = W_DATA'(v);
  endtask

  task automatic do_req(input logic [W_ADDR-1:0] b,
                        input logic [W_CNT-1:0] n,
                        input longint exp_sum,
                        input longint thr,
                        input bit exp_pass);
    int k;
    logic [W_ADDR-1:0] a;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(n); i++) begin
      a = b + W_ADDR'(i);
      addrq.push_back(a);
    end
    sumq.push_back(exp_sum);
`ifdef STAGE_THRESH_EN
    passq.push_back(exp_pass);
    req_thr = W_ACC'(thr);
`endif
    req_valid = 1'b1;
    req_base  = b;
    req_cnt   = n;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready && k < 100);
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sumq.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got %0d pending expected 0",
               sumq.size());
      sumq.delete();
      passq.delete();
    end
    chk("addr_left", longint'(addrq.size()), 0);
    addrq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_addr_valid"}, longint'(addr_valid), 0);
    chk({tag, "_sum_valid"}, longint'(sum_valid), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_data_ready"}, longint'(data_ready), 0);
    chk({tag, "_addr_data"}, longint'(addr_data), 0);
    chk({tag, "_sum_data"}, longint'(sum_data), 0);
    chk({tag, "_req_ready"}, longint'(req_ready), 1);
  endtask

  task automatic load_basic();
    set_rom(12'h010, 5);
    set_rom(12'h011, -3);
    set_rom(12'h012, 7);
    set_rom(12'h013, -1);
  endtask

  initial begin
    int k;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_base   = '0;
    req_cnt    = '0;
    addr_ready = 1'b1;
    data_valid = 1'b0;
    data       = '0;
    sum_ready  = 1'b1;
`ifdef STAGE_THRESH_EN
    req_thr    = '0;
`endif
    for (int i = 0; i < 4096; i++) rom[i] = '0;
    load_basic();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst0");
    rst = 1'b1;

    // basic, no stalls
    hs_cyc.delete();
    do_req(12'h010, 8'd4, 8, 8, 1);
    wait_done();
    if (hs_cyc.size() == 4) chk("consec", longint'(hs_cyc[3] - hs_cyc[0]), 3);
    else chk("consec_n", longint'(hs_cyc.size()), 4);

    // addr_ready toggling, sum_ready held low
    toggle    = 1'b1;
    sum_ready = 1'b0;
    do_req(12'h010, 8'd4, 8, 8, 1);
    k = 0;
    while (!sum_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    chk("hold_valid", longint'(sum_valid), 1);
    chk("hold_data", longint'($signed(sum_data)), 8);
    @(posedge clk);
    #1;
    sum_ready = 1'b1;
    wait_done();
    toggle = 1'b0;

    // cnt == 0
    n_av = 0;
    do_req(12'h123, 8'd0, 0, 0, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sum_valid && k < 20);
    chk("cnt0_lat", longint'(k), 2);
    wait_done();
    chk("cnt0_no_addr", longint'(n_av), 0);

    // address wrap, 3-cycle read latency
    lat = 3;
    max_pend = 0;
    set_rom(12'hFFE, 100);
    set_rom(12'hFFF, -200);
    set_rom(12'h000, 300);
    set_rom(12'h001, -50);
    do_req(12'hFFE, 8'd4, 150, 0, 1);
    wait_done();
    chk("max_out", longint'(max_pend), MAX_OUT);
    lat = 1;

    // full count of most negative values
    for (int i = 0; i < 255; i++) set_rom(12'h100 + 12'(i), -4096);
    do_req(12'h100, 8'd255, -1044480, 0, 0);
    wait_done();

    // reset in the middle of RUN
    n_ahs = 0;
    do_req(12'h010, 8'd4, 8, 8, 1);
    k = 0;
    while (n_ahs < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    addrq.delete();
    sumq.delete();
    passq.delete();
    pend.delete();
    data_valid = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    do_req(12'h010, 8'd4, 8, 8, 1);
    wait_done();

`ifdef STAGE_THRESH_EN
    do_req(12'h010, 8'd4, 8, 8, 1);
    wait_done();
    do_req(12'h010, 8'd4, 8, 9, 0);
    wait_done();
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
